// File: rtl/cv32e40s_rvfi_ifetch_tracker.sv
// rtl/cv32e40s_rvfi_ifetch_tracker.sv - in-order instruction fetch tracker feeding the RVFI instruction packer
// Optional fetch statistics outputs are enabled by defining CV32E40S_RVFI_IFETCH_STATS_EN.
module cv32e40s_rvfi_ifetch_tracker #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  obi_req_i,
  input  logic                  obi_gnt_i,
  input  logic [ADDR_WIDTH-1:0] obi_addr_i,
  input  logic [2:0]            obi_prot_i,
  input  logic [1:0]            obi_memtype_i,
  input  logic                  obi_rvalid_i,
  input  logic [31:0]           obi_rdata_i,
  input  logic                  obi_err_i,
  input  logic                  pmp_blk_i,
  input  logic [ADDR_WIDTH-1:0] pmp_addr_i,
  input  logic                  kill_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [ADDR_WIDTH-1:0] out_addr_o,
  output logic [2:0]            out_prot_o,
  output logic [1:0]            out_memtype_o,
  output logic [31:0]           out_rdata_o,
  output logic                  out_err_o,
  output logic                  out_pmp_err_o,
`ifdef CV32E40S_RVFI_IFETCH_STATS_EN
  output logic                  proto_err_o,
  output logic [31:0]           stat_fetch_o,
  output logic [31:0]           stat_err_o,
  output logic [31:0]           stat_kill_drop_o
`else
  output logic                  proto_err_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] addr_q    [DEPTH];
  logic [2:0]            prot_q    [DEPTH];
  logic [1:0]            memtype_q [DEPTH];
  logic [31:0]           rdata_q   [DEPTH];
  logic [DEPTH-1:0]      err_q;
  logic [DEPTH-1:0]      pmp_q;
  logic [DEPTH-1:0]      done_q;

  logic [PW-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0] pop_ptr_q, pop_ptr_d;
  logic [PW-1:0] resp_ptr;
  logic          resp_found;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic          proto_err_q, proto_err_d;

  logic gnt_fire, full, alloc_bus, alloc_pmp, alloc;
  logic rsp_discard, rsp_store, rsp_orphan;
  logic head_valid, pop;

  assign gnt_fire    = obi_req_i & obi_gnt_i;
  assign full        = (cnt_q == CW'(DEPTH));
  assign alloc_bus   = gnt_fire & ~full & ~kill_i;
  assign alloc_pmp   = pmp_blk_i & ~gnt_fire & ~full & ~kill_i;
  assign alloc       = alloc_bus | alloc_pmp;
  assign rsp_discard = obi_rvalid_i & (discard_q != '0);
  assign rsp_store   = obi_rvalid_i & (discard_q == '0) & (inflight_q != '0);
  assign rsp_orphan  = obi_rvalid_i & (discard_q == '0) & (inflight_q == '0);
  assign head_valid  = (cnt_q != '0) & done_q[pop_ptr_q];
  assign pop         = head_valid & out_ready_i;

  // Oldest live bus entry still waiting for data; PMP entries are born complete and skipped.
  always_comb begin
    resp_ptr   = pop_ptr_q;
    resp_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!resp_found && (CW'(i) < cnt_q) &&
          !pmp_q[pop_ptr_q + PW'(i)] && !done_q[pop_ptr_q + PW'(i)]) begin
        resp_found = 1'b1;
        resp_ptr   = pop_ptr_q + PW'(i);
      end
    end
  end

  always_comb begin
    alloc_ptr_d = alloc_ptr_q + PW'(alloc);
    pop_ptr_d   = pop_ptr_q + PW'(pop);
    cnt_d       = cnt_q + CW'(alloc) - CW'(pop);
    inflight_d  = inflight_q + CW'(alloc_bus) - CW'(rsp_store);
    discard_d   = discard_q - CW'(rsp_discard);
    proto_err_d = proto_err_q | (gnt_fire & pmp_blk_i) |
                  ((gnt_fire | pmp_blk_i) & full) | rsp_orphan;
    // A kill turns every outstanding bus request, including one granted now, into a response to drop.
    if (kill_i) begin
      alloc_ptr_d = '0;
      pop_ptr_d   = '0;
      cnt_d       = '0;
      inflight_d  = '0;
      discard_d   = discard_q + inflight_q + CW'(gnt_fire) - CW'(rsp_discard | rsp_store);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alloc_ptr_q <= '0;
      pop_ptr_q   <= '0;
      cnt_q       <= '0;
      inflight_q  <= '0;
      discard_q   <= '0;
      proto_err_q <= 1'b0;
      err_q       <= '0;
      pmp_q       <= '0;
      done_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]    <= '0;
        prot_q[i]    <= '0;
        memtype_q[i] <= '0;
        rdata_q[i]   <= '0;
      end
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      pop_ptr_q   <= pop_ptr_d;
      cnt_q       <= cnt_d;
      inflight_q  <= inflight_d;
      discard_q   <= discard_d;
      proto_err_q <= proto_err_d;
      if (alloc_bus) begin
        addr_q[alloc_ptr_q]    <= obi_addr_i;
        prot_q[alloc_ptr_q]    <= obi_prot_i;
        memtype_q[alloc_ptr_q] <= obi_memtype_i;
        rdata_q[alloc_ptr_q]   <= '0;
        err_q[alloc_ptr_q]     <= 1'b0;
        pmp_q[alloc_ptr_q]     <= 1'b0;
        done_q[alloc_ptr_q]    <= 1'b0;
      end else if (alloc_pmp) begin
        addr_q[alloc_ptr_q]    <= pmp_addr_i;
        prot_q[alloc_ptr_q]    <= '0;
        memtype_q[alloc_ptr_q] <= '0;
        rdata_q[alloc_ptr_q]   <= '0;
        err_q[alloc_ptr_q]     <= 1'b0;
        pmp_q[alloc_ptr_q]     <= 1'b1;
        done_q[alloc_ptr_q]    <= 1'b1;
      end
      if (rsp_store && resp_found) begin
        rdata_q[resp_ptr] <= obi_rdata_i;
        err_q[resp_ptr]   <= obi_err_i;
        done_q[resp_ptr]  <= 1'b1;
      end
    end
  end

  assign out_valid_o   = head_valid;
  assign out_addr_o    = head_valid ? addr_q[pop_ptr_q]    : '0;
  assign out_prot_o    = head_valid ? prot_q[pop_ptr_q]    : '0;
  assign out_memtype_o = head_valid ? memtype_q[pop_ptr_q] : '0;
  assign out_rdata_o   = head_valid ? rdata_q[pop_ptr_q]   : '0;
  assign out_err_o     = head_valid & err_q[pop_ptr_q];
  assign out_pmp_err_o = head_valid & pmp_q[pop_ptr_q];
  assign proto_err_o   = proto_err_q;

`ifdef CV32E40S_RVFI_IFETCH_STATS_EN
  logic [31:0] stat_fetch_q, stat_err_q, stat_kill_drop_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_fetch_q     <= '0;
      stat_err_q       <= '0;
      stat_kill_drop_q <= '0;
    end else begin
      if (pop && (stat_fetch_q != '1)) stat_fetch_q <= stat_fetch_q + 32'd1;
      if (pop && (err_q[pop_ptr_q] | pmp_q[pop_ptr_q]) && (stat_err_q != '1))
        stat_err_q <= stat_err_q + 32'd1;
      if (rsp_discard && (stat_kill_drop_q != '1)) stat_kill_drop_q <= stat_kill_drop_q + 32'd1;
    end
  end

  assign stat_fetch_o     = stat_fetch_q;
  assign stat_err_o       = stat_err_q;
  assign stat_kill_drop_o = stat_kill_drop_q;
`endif

endmodule
